// File: rtl/register_file_if.sv
// Register file access bundle: one write port and two read ports.
interface register_file_if #(
    parameter int unsigned N = 32
);
    logic         wr_ena;
    logic [4:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic [4:0]   rd_addr0;
    logic [4:0]   rd_addr1;
    logic [N-1:0] rd_data0;
    logic [N-1:0] rd_data1;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        output rd_data0, rd_data1
    );
endinterface

// File: rtl/register_file.sv
// 32 x N register file: x0 reads zero, two combinational read ports,
// one synchronous write port with optional same-cycle write forwarding.

// 32:1 N-bit selector used by each read port.
module mux32 #(
    parameter int unsigned N = 32
) (
    input  logic [31:0][N-1:0] din,
    input  logic [4:0]         sel,
    output logic [N-1:0]       dout
);
    assign dout = din[sel];
endmodule

module register_file #(
    parameter int unsigned N      = 32,
    parameter bit          BYPASS = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);
    localparam int unsigned NUM_REGS = 32;

    logic [NUM_REGS-1:1]         wr_sel;
    logic [NUM_REGS-1:0][N-1:0]  reg_out;
    logic [N-1:0]                mux_out0;
    logic [N-1:0]                mux_out1;
    logic                        fwd0;
    logic                        fwd1;

    // x0 has no storage; its selector input is tied low.
    assign reg_out[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [N-1:0] q;

        // One-hot decode of the write address; reset blocks every write.
        assign wr_sel[i] = bus.wr_ena && !rst && (bus.wr_addr == 5'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (wr_sel[i]) begin
                q <= bus.wr_data;
            end
        end

        assign reg_out[i] = q;
    end

    mux32 #(.N(N)) u_mux0 (
        .din  (reg_out),
        .sel  (bus.rd_addr0),
        .dout (mux_out0)
    );

    mux32 #(.N(N)) u_mux1 (
        .din  (reg_out),
        .sel  (bus.rd_addr1),
        .dout (mux_out1)
    );

    // Forwarding only for a live, non-x0 write outside reset.
    always_comb begin
        fwd0 = 1'b0;
        fwd1 = 1'b0;
        if (BYPASS && bus.wr_ena && !rst && (bus.wr_addr != 5'd0)) begin
            fwd0 = (bus.rd_addr0 == bus.wr_addr);
            fwd1 = (bus.rd_addr1 == bus.wr_addr);
        end
    end

    always_comb begin
        bus.rd_data0 = '0;
        bus.rd_data1 = '0;
        if (!rst) begin
            bus.rd_data0 = fwd0 ? bus.wr_data : mux_out0;
            bus.rd_data1 = fwd1 ? bus.wr_data : mux_out1;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Directed bench: one non-bypass and one bypass register file on shared stimulus.
module tb_register_file;
    localparam int unsigned N = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    register_file_if #(.N(N)) bus0 ();
    register_file_if #(.N(N)) bus1 ();

    assign bus1.wr_ena   = bus0.wr_ena;
    assign bus1.wr_addr  = bus0.wr_addr;
    assign bus1.wr_data  = bus0.wr_data;
    assign bus1.rd_addr0 = bus0.rd_addr0;
    assign bus1.rd_addr1 = bus0.rd_addr1;

    register_file #(.N(N), .BYPASS(1'b0)) u_dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    register_file #(.N(N), .BYPASS(1'b1)) u_dut_bp (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Single write cycle launched on a falling edge, enable dropped on the next.
    task automatic wr(input logic [4:0] addr, input logic [N-1:0] data);
        @(negedge clk);
        bus0.wr_ena  = 1'b1;
        bus0.wr_addr = addr;
        bus0.wr_data = data;
        @(negedge clk);
        bus0.wr_ena  = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus0.wr_ena   = 1'b0;
        bus0.wr_addr  = 5'd0;
        bus0.wr_data  = '0;
        bus0.rd_addr0 = 5'd5;
        bus0.rd_addr1 = 5'd31;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_nb_rd0", bus0.rd_data0, 32'h0);
        check("rst_bp_rd1", bus1.rd_data1, 32'h0);
        rst = 1'b0;

        // Preload x5, then assert reset asynchronously between edges
        wr(5'd5, 32'hDEAD_BEEF);
        check("preload_x5", bus0.rd_data0, 32'hDEAD_BEEF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_nb", bus0.rd_data0, 32'h0);
        check("async_rst_bp", bus1.rd_data0, 32'h0);

        // Writes and forwarding are suppressed during reset
        @(negedge clk);
        bus0.wr_ena  = 1'b1;
        bus0.wr_addr = 5'd5;
        bus0.wr_data = 32'h0000_0001;
        #1;
        check("rst_no_fwd", bus1.rd_data0, 32'h0);
        @(negedge clk);
        bus0.wr_ena = 1'b0;
        rst         = 1'b0;
        #1;
        check("rst_no_write", bus0.rd_data0, 32'h0);
        for (int a = 0; a < 32; a++) begin
            bus0.rd_addr0 = 5'(a);
            bus0.rd_addr1 = 5'(a);
            #1;
            check("post_rst_rd0", bus0.rd_data0, 32'h0);
            check("post_rst_rd1", bus1.rd_data1, 32'h0);
        end

        // First rising edge after release accepts a write
        wr(5'd9, 32'h0000_0099);
        bus0.rd_addr0 = 5'd9;
        #1;
        check("first_write", bus0.rd_data0, 32'h0000_0099);

        // Write all, sweep ports in opposite directions
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 + 32'(i));
        for (int a = 0; a < 32; a++) begin
            bus0.rd_addr0 = 5'(a);
            bus0.rd_addr1 = 5'(31 - a);
            #1;
            check("sweep_rd0", bus0.rd_data0, (a == 0) ? 32'h0 : 32'h1000_0000 + 32'(a));
            check("sweep_rd1", bus0.rd_data1, (a == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - a));
        end

        // x0 immutability, including no forwarding to address 0
        @(negedge clk);
        bus0.rd_addr0 = 5'd0;
        bus0.rd_addr1 = 5'd0;
        bus0.wr_ena   = 1'b1;
        bus0.wr_addr  = 5'd0;
        bus0.wr_data  = 32'hFFFF_FFFF;
        #1;
        check("x0_bp_same_cycle", bus1.rd_data1, 32'h0);
        @(negedge clk);
        bus0.wr_ena = 1'b0;
        check("x0_nb_after", bus0.rd_data0, 32'h0);
        check("x0_bp_after", bus1.rd_data0, 32'h0);
        for (int a = 1; a < 32; a++) begin
            bus0.rd_addr1 = 5'(a);
            #1;
            check("x0_no_side", bus0.rd_data1, 32'h1000_0000 + 32'(a));
        end

        // Write-enable gating
        wr(5'd7, 32'hAAAA_5555);
        @(negedge clk);
        bus0.wr_ena   = 1'b0;
        bus0.wr_addr  = 5'd7;
        bus0.wr_data  = 32'h1234_5678;
        bus0.rd_addr0 = 5'd7;
        @(negedge clk);
        check("wen_gate_nb", bus0.rd_data0, 32'hAAAA_5555);
        check("wen_gate_bp", bus1.rd_data0, 32'hAAAA_5555);

        // Same-cycle read/write hazard on x3
        wr(5'd3, 32'h0000_0011);
        @(negedge clk);
        bus0.rd_addr0 = 5'd3;
        bus0.rd_addr1 = 5'd0;
        bus0.wr_ena   = 1'b1;
        bus0.wr_addr  = 5'd3;
        bus0.wr_data  = 32'h0000_0022;
        #1;
        check("haz_nb_before", bus0.rd_data0, 32'h0000_0011);
        check("haz_bp_before", bus1.rd_data0, 32'h0000_0022);
        check("haz_bp_x0", bus1.rd_data1, 32'h0);
        @(posedge clk);
        #1;
        check("haz_nb_after", bus0.rd_data0, 32'h0000_0022);
        check("haz_bp_after", bus1.rd_data0, 32'h0000_0022);
        @(negedge clk);
        bus0.wr_ena = 1'b0;
        bus0.rd_addr1 = 5'd3;
        #1;
        check("haz_same_addr", bus0.rd_data1, bus0.rd_data0);
        check("haz_rd1_val", bus1.rd_data1, 32'h0000_0022);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
